// File: rtl/fu_seq.sv
// -----------------------------------------------------------------------------
// fu_seq -- functional-unit operation sequencer
//
// Accepts one operation request at a time and drives the functional unit and
// register-file selects for it. A request runs through IDLE -> EXEC -> DONE.
// Shift operations can be repeated several times, each pass feeding back the
// previous result.
//
// Build option:
//   FU_SEQ_REPEAT_EN  defined   -> shift ops (FSRA, FSLA, FSHR, FSHL) run
//                                  max(req_cnt,1) EXEC cycles; the passes after
//                                  the first read B from the destination.
//                     undefined -> req_cnt is ignored; every op takes exactly
//                                  one EXEC cycle; no repeat counter is built.
//
// Parameters:
//   RW          register select width (2**RW registers)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   sequencer can accept a request (IDLE only)
//   req_op      function select (fs_t encoding)
//   req_ra/rb/rd source A, source B, destination selects
//   req_cnt     repeat count for shift ops (0 and 1 mean one pass)
//   fs_out      function select to the functional unit (0 outside EXEC)
//   a_sel/b_sel/d_sel register-file selects (hold outside EXEC)
//   ld_out      register-file write enable (1 in every EXEC cycle)
//   z_in/n_in   zero / negative from the functional unit
//   z_flag/n_flag status flags of the last completed operation
//   done_out    one-cycle completion pulse
// -----------------------------------------------------------------------------
module fu_seq #(
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [RW-1:0] req_ra,
    input  logic [RW-1:0] req_rb,
    input  logic [RW-1:0] req_rd,
    input  logic [3:0]    req_cnt,
    output logic [3:0]    fs_out,
    output logic [RW-1:0] a_sel,
    output logic [RW-1:0] b_sel,
    output logic [RW-1:0] d_sel,
    output logic          ld_out,
    input  logic          z_in,
    input  logic          n_in,
    output logic          z_flag,
    output logic          n_flag,
    output logic          done_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] FSRA = 4'd4;
    localparam logic [3:0] FSLA = 4'd7;
    localparam logic [3:0] FSHR = 4'd13;
    localparam logic [3:0] FSHL = 4'd14;

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [3:0]    op_reg;
    logic [RW-1:0] a_sel_reg;
    logic [RW-1:0] b_sel_reg;
    logic [RW-1:0] d_sel_reg;
    logic          z_flag_reg;
    logic          n_flag_reg;
    logic          accept;
    logic          last_exec;

    assign accept = (state_reg == IDLE) && req_valid;

`ifdef FU_SEQ_REPEAT_EN
    // Remaining EXEC passes, including the current one. A count of 15 loads
    // as 15 and counts down to 1, so it never wraps.
    logic [3:0] cnt_reg;
    logic       is_shift;
    logic [3:0] eff_cnt;

    assign is_shift  = (req_op == FSRA) || (req_op == FSLA) ||
                       (req_op == FSHR) || (req_op == FSHL);
    assign eff_cnt   = (is_shift && (req_cnt > 4'd1)) ? req_cnt : 4'd1;
    assign last_exec = (cnt_reg <= 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 4'd0;
        end else if (accept) begin
            cnt_reg <= eff_cnt;
        end else if (state_reg == EXEC) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end
`else
    // Without repeat support every operation is a single pass.
    logic unused_cnt;
    assign unused_cnt = &{1'b0, req_cnt, FSRA, FSLA, FSHR, FSHL};
    assign last_exec  = 1'b1;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = EXEC;
            EXEC:    if (last_exec) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= 4'd0;
            a_sel_reg  <= '0;
            b_sel_reg  <= '0;
            d_sel_reg  <= '0;
            z_flag_reg <= 1'b0;
            n_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // Selects are loaded at acceptance so the first EXEC cycle
                // already presents ra/rb/rd; afterwards they simply hold.
                op_reg    <= req_op;
                a_sel_reg <= req_ra;
                b_sel_reg <= req_rb;
                d_sel_reg <= req_rd;
            end else if (state_reg == EXEC) begin
                if (last_exec) begin
                    z_flag_reg <= z_in;
                    n_flag_reg <= n_in;
                end else begin
                    // Later passes operate on the previous result.
                    b_sel_reg <= d_sel_reg;
                end
            end
        end
    end

    always_comb begin
        fs_out = 4'd0;
        if (state_reg == EXEC) fs_out = op_reg;
    end

    assign req_ready = (state_reg == IDLE);
    assign ld_out    = (state_reg == EXEC);
    assign done_out  = (state_reg == DONE);
    assign a_sel     = a_sel_reg;
    assign b_sel     = b_sel_reg;
    assign d_sel     = d_sel_reg;
    assign z_flag    = z_flag_reg;
    assign n_flag    = n_flag_reg;

endmodule

// File: tb/tb_fu_seq.sv
module tb_fu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'd0;
    logic [2:0] req_ra = 3'd0, req_rb = 3'd0, req_rd = 3'd0;
    logic [3:0] req_cnt = 4'd0;
    logic [3:0] fs_out;
    logic [2:0] a_sel, b_sel, d_sel;
    logic       ld_out;
    logic       z_in = 1'b0, n_in = 1'b0;
    logic       z_flag, n_flag, done_out;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic       is_done;
        logic [3:0] fs;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] d;
        logic       z;
        logic       n;
    } exp_t;

    exp_t sb[$];

    fu_seq #(.RW(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .req_cnt(req_cnt), .fs_out(fs_out), .a_sel(a_sel), .b_sel(b_sel),
        .d_sel(d_sel), .ld_out(ld_out), .z_in(z_in), .n_in(n_in),
        .z_flag(z_flag), .n_flag(n_flag), .done_out(done_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: output seen with empty scoreboard at %0t", nm, $time);
    endtask

    // Effective EXEC cycle count the design should use for an op.
    function automatic int eff(input logic [3:0] op, input logic [3:0] c);
        int  r;
        logic sh;
        r  = 1;
        sh = (op == 4'd4) || (op == 4'd7) || (op == 4'd13) || (op == 4'd14);
`ifdef FU_SEQ_REPEAT_EN
        if (sh && c > 4'd1) r = int'(c);
`else
        if (sh && c > 4'd1) r = 1;
`endif
        return r;
    endfunction

    task automatic push_op(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rd, input int n_wr, input logic z, input logic n,
                           input bit with_done);
        exp_t e;
        for (int k = 0; k < n_wr; k++) begin
            e = '{is_done: 1'b0, fs: op, a: ra, b: (k == 0) ? rb : rd, d: rd, z: 1'b0, n: 1'b0};
            sb.push_back(e);
        end
        if (with_done) begin
            e = '{is_done: 1'b1, fs: 4'd0, a: 3'd0, b: 3'd0, d: 3'd0, z: z, n: n};
            sb.push_back(e);
        end
    endtask

    // Monitor: compares every write cycle and every done pulse against the
    // scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ld_out) begin
                if (sb.size() == 0) unexpected("ld_out");
                else begin
                    e = sb.pop_front();
                    chk("wr_kind", int'(e.is_done), 0);
                    chk("wr_fs", int'(fs_out), int'(e.fs));
                    chk("wr_a", int'(a_sel), int'(e.a));
                    chk("wr_b", int'(b_sel), int'(e.b));
                    chk("wr_d", int'(d_sel), int'(e.d));
                    $display("write fs=%0d a=%0d b=%0d d=%0d", fs_out, a_sel, b_sel, d_sel);
                end
            end else begin
                chk("fs_idle", int'(fs_out), 0);
            end
            if (done_out) begin
                if (sb.size() == 0) unexpected("done_out");
                else begin
                    e = sb.pop_front();
                    chk("done_kind", int'(e.is_done), 1);
                    chk("z_flag", int'(z_flag), int'(e.z));
                    chk("n_flag", int'(n_flag), int'(e.n));
                    $display("done z=%0d n=%0d", z_flag, n_flag);
                end
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!req_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("ready_wait", int'(req_ready), 1);
    endtask

    // Issue one request (inputs driven at a negedge while IDLE), then scramble
    // the request inputs and check completion latency.
    task automatic do_op(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, input logic [3:0] cnt, input logic z,
                         input logic n);
        int e_cnt;
        int k;
        wait_ready();
        e_cnt = eff(op, cnt);
        push_op(op, ra, rb, rd, e_cnt, z, n, 1'b1);
        req_op = op; req_ra = ra; req_rb = rb; req_rd = rd; req_cnt = cnt;
        z_in = z; n_in = n;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = ~op; req_ra = ~ra; req_rb = ~rb; req_rd = ~rd; req_cnt = ~cnt;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!done_out) chk("ready_busy", int'(req_ready), 0);
        end while (!done_out && k < 40);
        chk("done_lat", k, e_cnt + 1);
        chk("ready_in_done", int'(req_ready), 0);
        @(negedge clk);
        chk("ready_after", int'(req_ready), 1);
        chk("ld_after", int'(ld_out), 0);
        $display("op=%0d ra=%0d rb=%0d rd=%0d cnt=%0d exec=%0d", op, ra, rb, rd, cnt, e_cnt);
    endtask

    initial begin
        int e_cnt;
        int n_ex;
        #1;
        // Reset state
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_ld", int'(ld_out), 0);
        chk("rst_done", int'(done_out), 0);
        chk("rst_fs", int'(fs_out), 0);
        chk("rst_sel", int'({a_sel, b_sel, d_sel}), 0);
        chk("rst_flags", int'({z_flag, n_flag}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(4'd2,  3'd1, 3'd2, 3'd3, 4'd0,  1'b0, 1'b1);  // FADD
        do_op(4'd14, 3'd0, 3'd4, 3'd5, 4'd3,  1'b1, 1'b0);  // FSHL x3
        do_op(4'd4,  3'd2, 3'd6, 3'd7, 4'd0,  1'b0, 1'b1);  // FSRA cnt 0
        do_op(4'd1,  3'd3, 3'd1, 3'd2, 4'd7,  1'b1, 1'b1);  // FINC cnt ignored
        do_op(4'd13, 3'd1, 3'd2, 3'd3, 4'd15, 1'b0, 1'b0);  // FSHR x15
        do_op(4'd10, 3'd7, 3'd6, 3'd5, 4'd2,  1'b1, 1'b0);  // FXOR cnt ignored

        // req_valid held high with a changing ra: accepted every 3 cycles.
        wait_ready();
        z_in = 1'b0; n_in = 1'b0;
        req_op = 4'd8; req_rb = 3'd2; req_rd = 3'd3; req_cnt = 4'd9;
        for (int i = 0; i < 9; i++) begin
            req_ra = 3'(i);
            req_valid = 1'b1;
            chk("b2b_ready", int'(req_ready), (i % 3 == 0) ? 1 : 0);
            if (i % 3 == 0) push_op(4'd8, 3'(i), 3'd2, 3'd3, 1, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_idle", int'(req_ready), 1);

        do_op(4'd3, 3'd4, 3'd5, 3'd6, 4'd0, 1'b1, 1'b1);    // FMUL, flags 1/1

        // Reset during EXEC of FSHR cnt=5 (2nd EXEC cycle when repeats exist).
        wait_ready();
        e_cnt = eff(4'd13, 4'd5);
        n_ex = (e_cnt >= 2) ? 2 : 1;
        push_op(4'd13, 3'd1, 3'd2, 3'd3, n_ex, 1'b0, 1'b0, 1'b0);
        req_op = 4'd13; req_ra = 3'd1; req_rb = 3'd2; req_rd = 3'd3; req_cnt = 4'd5;
        z_in = 1'b1; n_in = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < n_ex; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ld", int'(ld_out), 0);
        chk("mid_rst_ready", int'(req_ready), 1);
        chk("mid_rst_fs", int'(fs_out), 0);
        chk("mid_rst_sel", int'({a_sel, b_sel, d_sel}), 0);
        chk("mid_rst_flags", int'({z_flag, n_flag}), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("post_rst_flags", int'({z_flag, n_flag}), 0);
        chk("post_rst_ready", int'(req_ready), 1);
        $display("reset during op: exec cycles before reset=%0d", n_ex);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
